// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-look-ahead add/subtract unit.
package cla_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational W-bit carry-look-ahead adder built on a Kogge-Stone
// generate/propagate prefix tree; exposes the carry into the MSB for overflow.
module cla_segment #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W-1:0] p;
  logic [W-1:0] grp_g, grp_p;
  logic [W-1:0] nxt_g, nxt_p;
  logic [W:0]   c;

  always_comb begin
    // NOTE: every variable gets a value before any conditional or loop path,
    // so no storage is inferred.
    p     = a ^ b;
    grp_g = a & b;
    grp_p = p;
    nxt_g = '0;
    nxt_p = '0;
    c     = '0;
    // NOTE: blocking assignments here; each tree level must see the level
    // computed just above it within the same evaluation.
    for (int d = 1; d < W; d = d * 2) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = d; i < W; i++) begin
        nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        nxt_p[i] = grp_p[i] & grp_p[i-d];
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
    // grp_g/grp_p[i] now span bits [i:0], so every carry is one step from cin.
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = grp_g[i] | (grp_p[i] & cin);
    end
  end

  assign s        = p ^ c[W-1:0];
  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract: one CLA segment per stage with the carry registered
// between stages, valid/ready backpressure and registered status flags.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (!(is_pow2(WIDTH) && WIDTH >= 8 && WIDTH <= MAX_WIDTH &&
        (STAGES == 1 || STAGES == 2 || STAGES == 4) && (WIDTH % STAGES) == 0))
  begin : g_param_check
    $error("pipelined_cla_addsub: illegal WIDTH/STAGES combination");
  end

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] src_v;

  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             c_q     [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic             src_c   [STAGES];
  logic [SW-1:0]    seg_s   [STAGES];
  logic             seg_cout[STAGES];
  logic             seg_cmsb[STAGES];

  alu_flags_t flags_d, flags_q;

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s] = !vld[s] || adv[s+1];
    end
  end

  assign in_ready = adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK =
      ((WIDTH'(1) << SW) - WIDTH'(1)) << (s * SW);

    if (s == 0) begin : g_first
      assign src_v[s]   = in_valid;
      assign src_a[s]   = in_a;
      assign src_b[s]   = in_sub ? ~in_b : in_b;
      assign src_c[s]   = in_sub | in_cin;
      assign src_sum[s] = '0;
    end else begin : g_next
      assign src_v[s]   = vld[s-1];
      assign src_a[s]   = a_q[s-1];
      assign src_b[s]   = b_q[s-1];
      assign src_c[s]   = c_q[s-1];
      assign src_sum[s] = sum_q[s-1];
    end

    cla_segment #(.W(SW)) u_seg (
      .a        (src_a[s][s*SW +: SW]),
      .b        (src_b[s][s*SW +: SW]),
      .cin      (src_c[s]),
      .s        (seg_s[s]),
      .cout     (seg_cout[s]),
      .c_msb_in (seg_cmsb[s])
    );

    assign nxt_sum[s] = (src_sum[s] & ~SEG_MASK) | (WIDTH'(seg_s[s]) << (s * SW));
  end

  always_comb begin
    flags_d.cout = seg_cout[LAST];
    flags_d.ovf  = seg_cmsb[LAST] ^ seg_cout[LAST];
    flags_d.zero = (nxt_sum[LAST] == '0);
    flags_d.neg  = nxt_sum[LAST][WIDTH-1];
  end

  // NOTE: the data registers are reset as well, so a reset leaves the
  // result and flag outputs at 0 rather than holding stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      flags_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking updates, so every stage samples its predecessor's
      // value from before this edge.
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          vld[s] <= src_v[s];
          if (src_v[s]) begin
            a_q[s]   <= src_a[s];
            b_q[s]   <= src_b[s];
            sum_q[s] <= nxt_sum[s];
            c_q[s]   <= seg_cout[s];
          end
        end
      end
      if (adv[LAST] && src_v[LAST]) begin
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = vld[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = flags_q.cout;
  assign out_ovf   = flags_q.ovf;
  assign out_zero  = flags_q.zero;
  assign out_neg   = flags_q.neg;

endmodule
